// File: rtl/ceespu_pkg.sv
// Shared definitions for the ceespu SDRAM arbitration slice: arbiter
// state encoding, requester owner IDs and the default SDRAM address width.
package ceespu_pkg;

  localparam int unsigned SDRAM_ADDR_BITS = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/ceespu_outstanding_ctr.sv
// Count of SDRAM reads issued but not yet answered. Simultaneous increment
// and decrement leave the count unchanged; a decrement at zero is ignored.
module ceespu_outstanding_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_BITS = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty
);

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);

  // Saturating up/down count of in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + ONE;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign full  = (count == MAX_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/ceespu_sdram_arbiter.sv
// Two-requester (icache/dcache) SDRAM ownership arbiter. A requester owns
// the SDRAM for a whole burst; on release the arbiter drains outstanding
// reads before granting again. Read responses are routed by registered owner.
// Optional: define CEESPU_ARB_DCACHE_PRIORITY_EN to make dcache win every tie
// in IDLE (default build is round-robin on ties).
module ceespu_sdram_arbiter
  import ceespu_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = SDRAM_ADDR_BITS,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_i_req,
  input  logic                 I_i_cmd,
  input  logic [ADDR_BITS-1:0] I_i_addr,
  output logic                 O_i_gnt,
  output logic                 O_i_busy,
  output logic                 O_i_valid,
  input  logic                 I_d_req,
  input  logic                 I_d_cmd,
  input  logic [ADDR_BITS-1:0] I_d_addr,
  output logic                 O_d_gnt,
  output logic                 O_d_busy,
  output logic                 O_d_valid,
  input  logic                 I_d_iswrite,
  input  logic [31:0]          I_d_wdata,
  output logic [31:0]          O_rdata,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [31:0]          sdram_wdata,
  output logic                 sdram_iswrite,
  output logic                 sdram_new_command,
  input  logic [31:0]          sdram_data,
  input  logic                 sdram_valid,
  input  logic                 sdram_busy
);

  localparam int unsigned CNT_BITS = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [CNT_BITS-1:0] out_count;
  logic                out_full;
  logic                out_empty;
  logic                rd_accept;
  logic                resp_dec;

  // State and owner registers; owner resets to icache so the first tie goes to dcache.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state: grant from IDLE, hold until req drops, drain before re-arbitrating.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (I_i_req && I_d_req) begin
`ifdef CEESPU_ARB_DCACHE_PRIORITY_EN
          owner_d = OWNER_D;
`else
          owner_d = other_owner(owner_q);
`endif
          state_d = (owner_d == OWNER_D) ? OWN_D : OWN_I;
        end else if (I_i_req) begin
          owner_d = OWNER_I;
          state_d = OWN_I;
        end else if (I_d_req) begin
          owner_d = OWNER_D;
          state_d = OWN_D;
        end
      end
      OWN_I:   if (!I_i_req) state_d = DRAIN;
      OWN_D:   if (!I_d_req) state_d = DRAIN;
      DRAIN:   if (out_count == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign O_i_gnt  = (state_q == OWN_I);
  assign O_d_gnt  = (state_q == OWN_D);
  assign O_i_busy = !O_i_gnt || sdram_busy || out_full;
  assign O_d_busy = !O_d_gnt || sdram_busy || out_full;

  assign sdram_addr        = (owner_q == OWNER_D) ? I_d_addr : I_i_addr;
  assign sdram_iswrite     = (owner_q == OWNER_D) && I_d_iswrite;
  assign sdram_wdata       = (owner_q == OWNER_D) ? I_d_wdata : '0;
  assign sdram_new_command = ((O_i_gnt && I_i_cmd) || (O_d_gnt && I_d_cmd)) && !out_full;

  // Responses with nothing outstanding are stale (e.g. after reset) and dropped.
  assign rd_accept = sdram_new_command && !sdram_busy && !sdram_iswrite;
  assign resp_dec  = sdram_valid && !out_empty;

  assign O_rdata   = sdram_data;
  assign O_i_valid = sdram_valid && (state_q != IDLE) && (owner_q == OWNER_I);
  assign O_d_valid = sdram_valid && (state_q != IDLE) && (owner_q == OWNER_D);

  ceespu_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ctr (
    .clk  (I_clk),
    .rst  (I_rst),
    .inc  (rd_accept),
    .dec  (resp_dec),
    .count(out_count),
    .full (out_full),
    .empty(out_empty)
  );

endmodule

// File: tb/tb_ceespu_sdram_arbiter.sv
// Self-checking bench for ceespu_sdram_arbiter: directed scenarios plus a
// randomized run, every cycle compared against a behavioural ownership model.
module tb_ceespu_sdram_arbiter;

  localparam int unsigned AB   = 23;
  localparam int unsigned MAXO = 8;
`ifdef CEESPU_ARB_DCACHE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          I_clk = 1'b0;
  logic          I_rst;
  logic          I_i_req, I_i_cmd, I_d_req, I_d_cmd, I_d_iswrite;
  logic [AB-1:0] I_i_addr, I_d_addr;
  logic [31:0]   I_d_wdata;
  logic          O_i_gnt, O_i_busy, O_i_valid, O_d_gnt, O_d_busy, O_d_valid;
  logic [31:0]   O_rdata;
  logic [AB-1:0] sdram_addr;
  logic [31:0]   sdram_wdata, sdram_data;
  logic          sdram_iswrite, sdram_new_command, sdram_valid, sdram_busy;

  always #5 I_clk = ~I_clk;

  ceespu_sdram_arbiter #(.ADDR_BITS(AB), .MAX_OUTSTANDING(MAXO)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_i_req(I_i_req), .I_i_cmd(I_i_cmd), .I_i_addr(I_i_addr),
    .O_i_gnt(O_i_gnt), .O_i_busy(O_i_busy), .O_i_valid(O_i_valid),
    .I_d_req(I_d_req), .I_d_cmd(I_d_cmd), .I_d_addr(I_d_addr),
    .O_d_gnt(O_d_gnt), .O_d_busy(O_d_busy), .O_d_valid(O_d_valid),
    .I_d_iswrite(I_d_iswrite), .I_d_wdata(I_d_wdata), .O_rdata(O_rdata),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
    .sdram_iswrite(sdram_iswrite), .sdram_new_command(sdram_new_command),
    .sdram_data(sdram_data), .sdram_valid(sdram_valid), .sdram_busy(sdram_busy)
  );

  // Behavioural model: phase 0 = nobody owns, 1 = owning, 2 = releasing.
  int m_phase;
  int m_who;   // 0 icache, 1 dcache: current or most recent owner
  int m_out;   // reads in flight

  int n_checks = 0;
  int n_errors = 0;
  int obs_acc  = 0;
  int obs_vi   = 0;
  int obs_vd   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic step();
    bit          e_gi, e_gd, e_full, e_cmd, e_wr, e_vi, e_vd, e_acc, e_rd, e_dc;
    logic [31:0] e_addr, e_wdata;
    int          old_out;
    sdram_data = $urandom;
    #1;
    e_gi    = (m_phase == 1) && (m_who == 0);
    e_gd    = (m_phase == 1) && (m_who == 1);
    e_full  = (m_out == int'(MAXO));
    e_cmd   = ((e_gi && I_i_cmd) || (e_gd && I_d_cmd)) && !e_full;
    e_wr    = (m_who == 1) && I_d_iswrite;
    e_addr  = (m_who == 1) ? 32'(I_d_addr) : 32'(I_i_addr);
    e_wdata = (m_who == 1) ? I_d_wdata : 32'h0;
    e_vi    = sdram_valid && (m_phase != 0) && (m_who == 0);
    e_vd    = sdram_valid && (m_phase != 0) && (m_who == 1);
    check("gnt_i",   32'(O_i_gnt), 32'(e_gi));
    check("gnt_d",   32'(O_d_gnt), 32'(e_gd));
    check("busy_i",  32'(O_i_busy), 32'(!e_gi || sdram_busy || e_full));
    check("busy_d",  32'(O_d_busy), 32'(!e_gd || sdram_busy || e_full));
    check("valid_i", 32'(O_i_valid), 32'(e_vi));
    check("valid_d", 32'(O_d_valid), 32'(e_vd));
    check("new_cmd", 32'(sdram_new_command), 32'(e_cmd));
    check("addr",    32'(sdram_addr), e_addr);
    check("iswrite", 32'(sdram_iswrite), 32'(e_wr));
    check("wdata",   sdram_wdata, e_wdata);
    check("rdata",   O_rdata, sdram_data);
    check("out_cnt", 32'(dut.u_ctr.count), 32'(m_out));
    if (sdram_new_command && !sdram_busy) obs_acc++;
    if (O_i_valid) obs_vi++;
    if (O_d_valid) obs_vd++;
    @(posedge I_clk);
    if (I_rst) begin
      m_phase = 0;
      m_who   = 0;
      m_out   = 0;
    end else begin
      e_acc   = e_cmd && !sdram_busy;
      e_rd    = e_acc && !e_wr;
      e_dc    = sdram_valid && (m_out > 0);
      old_out = m_out;
      m_out   = m_out + int'(e_rd) - int'(e_dc);
      case (m_phase)
        0: begin
          if (I_i_req && I_d_req) begin
            m_who   = PRIO ? 1 : 1 - m_who;
            m_phase = 1;
          end else if (I_i_req) begin
            m_who   = 0;
            m_phase = 1;
          end else if (I_d_req) begin
            m_who   = 1;
            m_phase = 1;
          end
        end
        1: if (!((m_who == 0) ? I_i_req : I_d_req)) m_phase = 2;
        default: if (old_out == 0) m_phase = 0;
      endcase
    end
    @(negedge I_clk);
  endtask

  task automatic quiet();
    I_i_req = 0; I_i_cmd = 0; I_d_req = 0; I_d_cmd = 0; I_d_iswrite = 0;
    sdram_valid = 0; sdram_busy = 0;
  endtask

  task automatic do_reset();
    quiet();
    I_rst = 1;
    step();
    step();
    I_rst = 0;
  endtask

  initial begin
    int acc0, v0, n, guard;
    I_rst = 1; quiet();
    I_i_addr = '0; I_d_addr = '0; I_d_wdata = '0; sdram_data = '0;
    m_phase = 0; m_who = 0; m_out = 0;
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    step();
    check("rst_gnt_i", 32'(O_i_gnt), 32'd0);
    check("rst_busy_d", 32'(O_d_busy), 32'd1);
    I_rst = 0;

    // icache single burst: 8 reads, 8 responses, release
    I_i_req = 1;
    step();
    check("s21_gnt", 32'(O_i_gnt), 32'd1);
    acc0 = obs_acc; v0 = obs_vi;
    for (int unsigned k = 0; k < 8; k++) begin
      I_i_cmd = 1; I_i_addr = AB'(k);
      step();
    end
    I_i_cmd = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      sdram_valid = 1;
      step();
    end
    sdram_valid = 0;
    check("s21_cmds", 32'(obs_acc - acc0), 32'd8);
    check("s21_valids", 32'(obs_vi - v0), 32'd8);
    I_i_req = 0;
    step();
    check("s21_drain_gnt", 32'(O_i_gnt), 32'd0);
    step();
    step();

    // simultaneous requests after reset
    do_reset();
    I_i_req = 1; I_d_req = 1;
    step();
    check("s22_first_d", 32'(O_d_gnt), 32'd1);
    I_i_cmd = 1;
    step();
    check("s22_no_preempt", 32'(O_i_gnt), 32'd0);
    I_i_cmd = 0; I_i_req = 0; I_d_req = 0;
    step();
    step();
    I_i_req = 1; I_d_req = 1;
    step();
    check("s22_second_i", 32'(O_i_gnt), PRIO ? 32'd0 : 32'd1);
    check("s22_second_d", 32'(O_d_gnt), PRIO ? 32'd1 : 32'd0);
    quiet();
    step();
    step();

    // dcache fills the outstanding window
    do_reset();
    I_d_req = 1;
    step();
    for (int unsigned k = 0; k < 8; k++) begin
      I_d_cmd = 1; I_d_addr = AB'(32'h40 + k);
      step();
    end
    #1;
    check("s23_busy9", 32'(O_d_busy), 32'd1);
    check("s23_cmd9", 32'(sdram_new_command), 32'd0);
    sdram_valid = 1;
    step();
    sdram_valid = 0;
    #1;
    check("s23_cmd_after", 32'(sdram_new_command), 32'd1);
    step();
    I_d_cmd = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      sdram_valid = 1;
      step();
    end
    quiet();
    step();
    step();

    // dcache write burst with a toggling busy
    I_d_req = 1;
    step();
    acc0 = obs_acc; n = 0; guard = 0;
    while (n < 8 && guard < 100) begin
      I_d_cmd = 1; I_d_iswrite = 1;
      I_d_addr = AB'(32'h100 + n); I_d_wdata = 32'hDEAD0000 + 32'(n);
      sdram_busy = guard[0];
      guard++;
      if (!sdram_busy) n++;
      step();
    end
    check("s24_writes", 32'(obs_acc - acc0), 32'd8);
    check("s24_count", 32'(dut.u_ctr.count), 32'd0);
    quiet();
    step();
    check("s24_release", 32'(O_d_gnt), 32'd0);
    step();

    // reset mid-burst, then stale responses
    I_i_req = 1;
    step();
    for (int unsigned k = 0; k < 3; k++) begin
      I_i_cmd = 1;
      step();
    end
    quiet();
    I_rst = 1;
    step();
    I_rst = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      sdram_valid = 1;
      #1;
      check("s25_stale_vi", 32'(O_i_valid), 32'd0);
      step();
    end
    sdram_valid = 0;
    check("s25_count", 32'(dut.u_ctr.count), 32'd0);
    I_i_req = 1;
    step();
    check("s25_regrant", 32'(O_i_gnt), 32'd1);

    // randomized traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      if ($urandom_range(9) == 0) I_i_req = ~I_i_req;
      if ($urandom_range(9) == 0) I_d_req = ~I_d_req;
      I_i_cmd     = $urandom_range(1);
      I_d_cmd     = $urandom_range(1);
      I_d_iswrite = ($urandom_range(3) == 0);
      I_i_addr    = AB'($urandom);
      I_d_addr    = AB'($urandom);
      I_d_wdata   = $urandom;
      sdram_busy  = ($urandom_range(3) == 0);
      sdram_valid = ($urandom_range(2) == 0);
      I_rst       = ($urandom_range(299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
